// File: rtl/lcd_st7789_rx.sv
// ST7789 4-wire serial receiver: turns cs/sck/sd/rs pin activity into tagged bytes and
// decodes CASET/RASET/RAMWR into addressed RGB565 pixel writes for checking a panel driver.
module lcd_st7789_rx #(
    parameter int COLS        = 240,
    parameter int ROWS        = 280,
    parameter int COORD_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lcd_rst,
    input  logic                   lcd_cs,
    input  logic                   lcd_sck,
    input  logic                   lcd_sd,
    input  logic                   lcd_rs,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_is_cmd,
    output logic                   pix_valid,
    output logic [COORD_WIDTH-1:0] pix_x,
    output logic [COORD_WIDTH-1:0] pix_y,
    output logic [15:0]            pix_data,
    output logic                   sleep_out,
    output logic                   disp_on,
    output logic                   cmd_err,
    output logic [2:0]             dbg_state
);
    localparam int CW = COORD_WIDTH;
    localparam logic [CW-1:0] XE_RST = CW'(COLS - 1);
    localparam logic [CW-1:0] YE_RST = CW'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_RASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          cs_s1_q, cs_s1_d, sck_s1_q, sck_s1_d, sd_s1_q, sd_s1_d;
    logic          rs_s1_q, rs_s1_d, lrst_s1_q, lrst_s1_d, sck_s2_q, sck_s2_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shreg_q, shreg_d;
    logic [1:0]    par_cnt_q, par_cnt_d;
    logic [23:0]   par_q, par_d;
    logic [7:0]    hi_q, hi_d;
    logic          have_hi_q, have_hi_d;
    logic [CW-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic          byte_valid_q, byte_valid_d, byte_is_cmd_q, byte_is_cmd_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]   pix_data_q, pix_data_d;
    logic          sleep_q, sleep_d, disp_q, disp_d, cmd_err_q, cmd_err_d;

    logic          rise, byte_done, do_swreset;
    logic [7:0]    rx_byte;
    logic [15:0]   s_val, e_val;

    always_comb begin
        cs_s1_d   = lcd_cs;
        sck_s1_d  = lcd_sck;
        sd_s1_d   = lcd_sd;
        rs_s1_d   = lcd_rs;
        lrst_s1_d = lcd_rst;
        sck_s2_d  = sck_s1_q;

        rise      = sck_s1_q & ~sck_s2_q & ~cs_s1_q;
        byte_done = rise & lrst_s1_q & (bit_cnt_q == 3'd7);
        rx_byte   = {shreg_q, sd_s1_q};

        // A completing byte is taken first; a raised cs then still clears the counter.
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {shreg_q[5:0], sd_s1_q};
        end
        if (cs_s1_q || !lrst_s1_q) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
        end

        byte_valid_d  = byte_done;
        byte_data_d   = byte_data_q;
        byte_is_cmd_d = byte_is_cmd_q;
        if (byte_done) begin
            byte_data_d   = rx_byte;
            byte_is_cmd_d = rs_s1_q;
        end

        state_d     = state_q;
        par_cnt_d   = par_cnt_q;
        par_d       = par_q;
        hi_d        = hi_q;
        have_hi_d   = have_hi_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
        sleep_d     = sleep_q;
        disp_d      = disp_q;
        cmd_err_d   = cmd_err_q;

        s_val      = {par_q[23:16], par_q[15:8]};
        e_val      = {par_q[7:0], rx_byte};
        do_swreset = ~lrst_s1_q | (byte_done & rs_s1_q & (rx_byte == 8'h01));

        if (byte_done && rs_s1_q) begin
            par_cnt_d = '0;
            have_hi_d = 1'b0;
            state_d   = ST_IDLE;
            case (rx_byte)
                8'h2A: state_d = ST_CASET;
                8'h2B: state_d = ST_RASET;
                8'h2C: begin
                    state_d = ST_RAMWR;
                    cx_d    = xs_q;
                    cy_d    = ys_q;
                end
                8'h10: sleep_d = 1'b0;
                8'h11: sleep_d = 1'b1;
                8'h28: disp_d = 1'b0;
                8'h29: disp_d = 1'b1;
                8'h00, 8'h01: ;
                default: state_d = ST_SKIP;
            endcase
        end else if (byte_done) begin
            case (state_q)
                ST_CASET, ST_RASET: begin
                    // par_q holds p0,p1,p2 once three params are in; p3 is the live byte.
                    par_d     = {par_q[15:0], rx_byte};
                    par_cnt_d = par_cnt_q + 2'd1;
                    if (par_cnt_q == 2'd3) begin
                        state_d = ST_SKIP;
                        if (s_val <= e_val) begin
                            if (state_q == ST_CASET) begin
                                xs_d = s_val[CW-1:0];
                                xe_d = e_val[CW-1:0];
                            end else begin
                                ys_d = s_val[CW-1:0];
                                ye_d = e_val[CW-1:0];
                            end
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                ST_RAMWR: begin
                    if (!have_hi_q) begin
                        hi_d      = rx_byte;
                        have_hi_d = 1'b1;
                    end else begin
                        have_hi_d   = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_x_d     = cx_q;
                        pix_y_d     = cy_q;
                        pix_data_d  = {hi_q, rx_byte};
                        if (cx_q == xe_q) begin
                            cx_d = xs_q;
                            cy_d = (cy_q == ye_q) ? ys_q : cy_q + CW'(1);
                        end else begin
                            cx_d = cx_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        if (do_swreset) begin
            state_d   = ST_IDLE;
            par_cnt_d = '0;
            have_hi_d = 1'b0;
            xs_d      = '0;
            xe_d      = XE_RST;
            ys_d      = '0;
            ye_d      = YE_RST;
            sleep_d   = 1'b0;
            disp_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cs_s1_q       <= 1'b1;
            sck_s1_q      <= 1'b0;
            sd_s1_q       <= 1'b0;
            rs_s1_q       <= 1'b0;
            lrst_s1_q     <= 1'b1;
            sck_s2_q      <= 1'b0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            par_cnt_q     <= '0;
            par_q         <= '0;
            hi_q          <= '0;
            have_hi_q     <= 1'b0;
            xs_q          <= '0;
            xe_q          <= XE_RST;
            ys_q          <= '0;
            ye_q          <= YE_RST;
            cx_q          <= '0;
            cy_q          <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_is_cmd_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            sleep_q       <= 1'b0;
            disp_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_s1_q       <= cs_s1_d;
            sck_s1_q      <= sck_s1_d;
            sd_s1_q       <= sd_s1_d;
            rs_s1_q       <= rs_s1_d;
            lrst_s1_q     <= lrst_s1_d;
            sck_s2_q      <= sck_s2_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            par_cnt_q     <= par_cnt_d;
            par_q         <= par_d;
            hi_q          <= hi_d;
            have_hi_q     <= have_hi_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            byte_is_cmd_q <= byte_is_cmd_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            sleep_q       <= sleep_d;
            disp_q        <= disp_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_is_cmd = byte_is_cmd_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign sleep_out   = sleep_q;
    assign disp_on     = disp_q;
    assign cmd_err     = cmd_err_q;
    assign dbg_state   = state_q;
endmodule
